// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, DATA_W payload bits LSB-first, stop bit.
// Optional even-parity bit between payload and stop when SERIAL_FRAME_TX_PARITY_EN is defined.
module serial_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] DIN,
  input  logic              LOAD,
  output logic              READY,
  output logic              TX,
  output logic              BUSY,
  output logic              DONE
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [BW-1:0]     bit_cnt, bit_n;
  logic [DATA_W-1:0] shadow, shadow_n;
  logic              tx_n, ready_n, done_n;
  logic              last_clk;

  assign last_clk = (cnt == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_n  = state;
    cnt_n    = last_clk ? '0 : cnt + CW'(1);
    bit_n    = bit_cnt;
    shadow_n = shadow;
    tx_n     = TX;
    ready_n  = READY;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n   = '0;
        tx_n    = 1'b1;
        ready_n = 1'b1;
        if (LOAD) begin
          shadow_n = DIN;
          state_n  = START;
          tx_n     = 1'b0;
          ready_n  = 1'b0;
        end
      end
      START: begin
        if (last_clk) begin
          state_n = DATA;
          bit_n   = '0;
          tx_n    = shadow[0];
        end
      end
      DATA: begin
        if (last_clk) begin
          if (bit_cnt == BW'(DATA_W - 1)) begin
            bit_n = '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = ^shadow;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            bit_n = bit_cnt + BW'(1);
            tx_n  = shadow[bit_n];
          end
        end
      end
      PARITY: begin
        if (last_clk) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        // Frame ends here; READY and DONE rise together so a LOAD in the DONE cycle is taken.
        if (last_clk) begin
          state_n = IDLE;
          ready_n = 1'b1;
          done_n  = 1'b1;
          tx_n    = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        bit_n   = '0;
        tx_n    = 1'b1;
        ready_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shadow  <= '0;
      TX      <= 1'b1;
      READY   <= 1'b1;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_n;
      shadow  <= shadow_n;
      TX      <= tx_n;
      READY   <= ready_n;
      BUSY    <= ~ready_n;
      DONE    <= done_n;
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: table of known frames, hand-written corner sequences, random frames.
module tb_serial_frame_tx;

  localparam int N = 8;
  localparam int C = 4;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int NB = N + 3;
`else
  localparam int NB = N + 2;
`endif
  localparam int L = NB * C;

  logic         CLOCK = 1'b0;
  logic         RESET;
  logic [N-1:0] DIN;
  logic         LOAD;
  logic         READY, TX, BUSY, DONE;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] din;
    logic [9:0] line;
    logic       par;
  } vec_t;
  vec_t tbl[6];

  serial_frame_tx #(.DATA_W(N), .CLKS_PER_BIT(C)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .DIN(DIN), .LOAD(LOAD),
    .READY(READY), .TX(TX), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference: which line level belongs to cycle j (1-based) of a frame carrying d.
  function automatic logic exp_tx(input logic [N-1:0] d, input int j);
    int k;
    k = (j - 1) / C;
    if (k == 0) return 1'b0;
    if (k <= N) return d[k-1];
`ifdef SERIAL_FRAME_TX_PARITY_EN
    if (k == N + 1) return ^d;
`endif
    return 1'b1;
  endfunction

  function automatic logic [10:0] exp_line(input logic [N-1:0] d);
`ifdef SERIAL_FRAME_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {2'b11, d, 1'b0};
`endif
  endfunction

  // Called at a negedge while idle; returns at the negedge of cycle 1.
  task automatic start_frame(input logic [N-1:0] d);
    DIN  = d;
    LOAD = 1'b1;
    @(negedge CLOCK);
    LOAD = 1'b0;
  endtask

  task automatic frame_body(input logic [N-1:0] d, input bit disturb, input bit nxt,
                            input logic [N-1:0] nd, output logic [10:0] line);
    line = '1;
    for (int j = 1; j <= L; j++) begin
      chk("frame_cycle", 32'({TX, READY, BUSY, DONE}), 32'({exp_tx(d, j), 3'b010}));
      if ((j - 1) % C == C / 2) line[(j - 1) / C] = TX;
      if (disturb) begin
        DIN  = (j == 15) ? 8'hFF : N'($urandom);
        LOAD = (j == 15);
      end
      @(negedge CLOCK);
    end
    chk("done_cycle", 32'({TX, READY, BUSY, DONE}), 32'(4'b1101));
    if (nxt) begin
      DIN  = nd;
      LOAD = 1'b1;
    end else begin
      LOAD = 1'b0;
    end
    @(negedge CLOCK);
    LOAD = 1'b0;
  endtask

  initial begin
    logic [10:0] line;
    logic [7:0]  d;

    tbl[0] = '{8'hA5, 10'b1_10100101_0, 1'b0};
    tbl[1] = '{8'h3C, 10'b1_00111100_0, 1'b0};
    tbl[2] = '{8'h07, 10'b1_00000111_0, 1'b1};
    tbl[3] = '{8'hFF, 10'b1_11111111_0, 1'b0};
    tbl[4] = '{8'h00, 10'b1_00000000_0, 1'b0};
    tbl[5] = '{8'h01, 10'b1_00000001_0, 1'b1};

    RESET = 1'b0;
    LOAD  = 1'b0;
    DIN   = '0;
    repeat (2) @(negedge CLOCK);
    chk("in_reset", 32'({TX, READY, BUSY, DONE}), 32'(4'b1100));
    RESET = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLOCK);
      chk("idle", 32'({TX, READY, BUSY, DONE}), 32'(4'b1100));
    end

    // Table frames sent back-to-back, each LOAD issued in the previous DONE cycle.
    start_frame(tbl[0].din);
    for (int i = 0; i < 6; i++) begin
      frame_body(tbl[i].din, 1'b0, (i < 5), tbl[(i < 5) ? i + 1 : i].din, line);
      chk("tbl_start_data", 32'(line[8:0]), 32'(tbl[i].line[8:0]));
`ifdef SERIAL_FRAME_TX_PARITY_EN
      chk("tbl_parity", 32'(line[9]), 32'(tbl[i].par));
      chk("tbl_stop", 32'(line[10]), 32'(tbl[i].line[9]));
`else
      chk("tbl_stop", 32'(line[9]), 32'(tbl[i].line[9]));
`endif
    end
    chk("after_chain", 32'({TX, READY, BUSY, DONE}), 32'(4'b1100));

    // DIN churn and a mid-frame LOAD must not disturb or queue.
    start_frame(8'hA5);
    frame_body(8'hA5, 1'b1, 1'b0, 8'h00, line);
    chk("churn_line", 32'(line), 32'(exp_line(8'hA5)));
    for (int i = 0; i < 3; i++) begin
      chk("no_second_frame", 32'({TX, READY, BUSY, DONE}), 32'(4'b1100));
      @(negedge CLOCK);
    end

    // Asynchronous reset in the middle of a frame.
    start_frame(8'hA5);
    repeat (19) @(negedge CLOCK);
    chk("pre_reset_busy", 32'(READY), 32'(1'b0));
    RESET = 1'b0;
    #1;
    chk("async_reset", 32'({TX, READY, BUSY, DONE}), 32'(4'b1100));
    DIN  = 8'h5A;
    LOAD = 1'b1;
    @(negedge CLOCK);
    chk("load_in_reset", 32'({TX, READY, BUSY, DONE}), 32'(4'b1100));
    LOAD  = 1'b0;
    RESET = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLOCK);
      chk("idle_after_reset", 32'({TX, READY, BUSY, DONE}), 32'(4'b1100));
    end
    start_frame(8'h96);
    frame_body(8'h96, 1'b0, 1'b0, 8'h00, line);
    chk("post_reset_line", 32'(line), 32'(exp_line(8'h96)));

    // Random frames, some chained, some with idle gaps.
    for (int i = 0; i < 20; i++) begin
      d = N'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge CLOCK);
      start_frame(d);
      frame_body(d, 1'b0, 1'b0, 8'h00, line);
      chk("rand_line", 32'(line), 32'(exp_line(d)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parallel-in, serial-out frame transmitter: the sending end of the team's serial status link. It accepts a DATA_W-bit word and shifts it out LSB-first with start and stop bits.
- Sits between the controller's registered status word (flip-flop bank) and the single-wire link to the display/receiver board.
- Uses a ready/load handshake with an internal shadow copy, so the source register may change while a frame is on the wire.

Parameters:
- DATA_W, 8, payload bits per frame (≥1)
- CLKS_PER_BIT, 4, CLOCK cycles each serial bit is held on TX (≥1)

Ports:
- CLOCK  input  1  single system clock, rising-edge
- RESET  input  1  asynchronous reset, active-low (RESET=0 resets)
- DIN    input  DATA_W  word to send
- LOAD   input  1  request to send DIN
- READY  output  1  1 = idle, LOAD will be accepted
- TX     output  1  serial line, idles high
- BUSY   output  1  1 = frame in progress (always the inverse of READY)
- DONE   output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (RESET=0, asynchronous, takes effect immediately, also mid-frame):
  - Outputs: TX=1, READY=1, BUSY=0, DONE=0.
  - Internal state: FSM=IDLE, bit counter=0, cycle counter=0, shadow register=0.
  - LOAD is ignored while RESET=0.
- FSM states IDLE → START → DATA → STOP → IDLE. All outputs are registered.
- Accept:
  - A LOAD=1 sampled at a rising edge with READY=1 captures DIN into the shadow register and moves the FSM to START. This edge is cycle 0.
  - LOAD=1 while BUSY=1 is ignored: no queueing, no error.
- Timing, with C=CLKS_PER_BIT and N=DATA_W:
  - START: TX=0 for cycles 1..C.
  - DATA: bit k (k=0..N-1, LSB first) on TX for cycles (k+1)·C+1 .. (k+2)·C.
  - STOP: TX=1 for cycles (N+1)·C+1 .. (N+2)·C.
  - Cycle (N+2)·C+1: FSM=IDLE, READY=1, DONE=1 for exactly one cycle, TX=1.
- Back-to-back frames:
  - LOAD=1 during the DONE cycle is accepted.
  - The next START begins the following cycle.
  - Idle gap between stop and start is one cycle of TX=1.
- Cycle counter:
  - Width is clog2(C), minimum 1 bit.
  - Counts 0..C-1 and wraps to 0 on each bit boundary.
  - For C=1 every state lasts exactly one cycle per bit.
- Bit counter:
  - Width is clog2(N), minimum 1 bit.
  - Counts 0..N-1 in DATA and clears on entry to STOP.
- DIN changes after the accept edge have no effect on the frame in progress.
- Glitch-free TX: TX changes only on rising CLOCK edges.

Optional Feature:
- Macro: SERIAL_FRAME_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - TX during PARITY = even parity, i.e. XOR of the N shadow bits, held for C cycles.
  - Frame length becomes (N+3)·C, and DONE moves to cycle (N+3)·C+1.
- Undefined: no PARITY state; timing exactly as in Behaviour.

Test Plan:
1. Reset, then idle 10 cycles → TX=1, READY=1, BUSY=0, DONE=0 throughout.
2. DATA_W=8, C=4, DIN=8'hA5, one-cycle LOAD → TX = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (cycles 1..40); DONE=1 only at cycle 41.
3. LOAD again with DIN=8'h3C in the DONE cycle of scenario 2 → second start bit begins the next cycle; line reads back 0x3C; no lost or extra bits.
4. Mid-frame LOAD with DIN=8'hFF at cycle 15, and DIN toggled every cycle during the frame → frame still carries the 0xA5 bit sequence; no second frame starts.
5. RESET=0 pulse at cycle 20 of a frame → TX=1 and READY=1 asynchronously (before the next edge); after release, idle until a new LOAD; the new frame is correct.
6. With SERIAL_FRAME_TX_PARITY_EN, C=1: DIN=8'hA5 → parity bit 0; DIN=8'h07 → parity bit 1; frame 11 cycles, DONE at cycle 12.
